regfile_write_arbiter: RTL and testbench
========================================

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter DEPTH, default 4: external-write FIFO entries, power of two, 2..16.
REQ-002 Parameter STARVE_LIMIT, default 16: consecutive blocked cycles before a forced grant, 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous assert, active-low; deassertion is synchronous to clk.
REQ-005 cpu_we  input  1  processor register-write enable.
REQ-006 cpu_rd  input  5  processor destination register.
REQ-007 cpu_data  input  32  processor write data.
REQ-008 ext_req  input  1  external writer (score logic) request; held until ext_ack.
REQ-009 ext_rd  input  5  external destination register; stable while ext_req high.
REQ-010 ext_data  input  32  external write data; stable while ext_req high.
REQ-011 ext_ack  output  1  request accepted this cycle.
REQ-012 rf_we  output  1  regfile write enable.
REQ-013 rf_rd  output  5  regfile write address.
REQ-014 rf_data  output  32  regfile write data.
REQ-015 cpu_stall  output  1  processor must freeze this cycle; its write is not performed.
REQ-016 pending  output  5  FIFO occupancy, 0..DEPTH.

Function
REQ-017 ext_ack SHALL equal ext_req & (pending != DEPTH) & reset_n, depending on registered occupancy only, never on same-cycle pop.
REQ-018 Transfer occurs on a clk edge with ext_req & ext_ack; ext_rd != 0 pushes {ext_rd, ext_data} to the FIFO tail; ext_rd == 0 is acked and discarded (no push, pending unchanged).
REQ-019 FSM states SHALL be IDLE (FIFO empty), PEND (FIFO non-empty), FORCE (forced external grant).
REQ-020 IDLE: rf_* = cpu_* (rf_we = cpu_we); push -> PEND next cycle; a pushed entry is never written in its push cycle.
REQ-021 PEND, cpu_we = 1: rf_* = cpu_*; blocked counter increments; if counter reaches STARVE_LIMIT-1 in this cycle, next state FORCE.
REQ-022 PEND, cpu_we = 0: rf_we = 1, rf_rd/rf_data = FIFO head; pop; counter cleared; next state IDLE if FIFO becomes empty (no simultaneous push), else PEND.
REQ-023 FORCE: cpu_stall = 1 combinationally; rf_we = 1 from FIFO head regardless of cpu_we; pop; counter cleared; next IDLE or PEND per resulting occupancy; FORCE lasts exactly one cycle.
REQ-024 cpu_stall SHALL be 0 in IDLE and PEND.
REQ-025 Simultaneous push and pop SHALL keep pending unchanged; FIFO order is strict first-in first-out, pointers wrap modulo DEPTH.
REQ-026 No ordering is guaranteed between CPU and external writes to the same register; last committed write wins.
REQ-027 Blocked counter width 8 bits, never exceeds STARVE_LIMIT-1, cleared on every pop and in IDLE.
REQ-028 Latency: with cpu_we = 0 continuously, an accepted external write reaches rf_we exactly 1 cycle after its ack edge.
REQ-029 rf_rd/rf_data SHALL be 0 whenever rf_we = 0.

Reset
REQ-030 While reset_n = 0: state IDLE, pending 0, FIFO pointers 0, counter 0, rf_we 0, rf_rd 0, rf_data 0, cpu_stall 0, ext_ack 0, independent of clk.
REQ-031 Reset mid-operation SHALL discard all FIFO contents; no queued write is emitted after reset_n rises.
REQ-032 First transfer possible on the first rising edge with reset_n = 1.

Verification
REQ-033 Idle pass-through: cpu_we=1, cpu_rd=5, cpu_data=0x1234, FIFO empty -> rf_we=1, rf_rd=5, rf_data=0x1234, cpu_stall=0 same cycle.
REQ-034 Slot steal: ext_req rd=30 data=7 acked at edge N, cpu_we=0 -> edge N+1 writes rd=30 data=7, pending back to 0.
REQ-035 Starvation: STARVE_LIMIT=4, one queued entry, cpu_we held 1 -> PEND 4 cycles, then one FORCE cycle with cpu_stall=1 and rf writes the queued entry, then IDLE.
REQ-036 Full: DEPTH=4, cpu_we=1, five requests -> first four acked, pending=4, fifth ext_ack=0 until a pop; pop order matches push order.
REQ-037 Zero register: ext_req rd=0 data=9 -> ext_ack=1, pending stays 0, no rf_we from external source.
REQ-038 Async reset: pending=3, reset_n pulsed low mid-cycle -> outputs 0 immediately; after release, no queued write ever appears on rf_*.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Register-file write port arbiter: the processor owns the port by default; the
// external writer queues into a small FIFO and uses free slots or a forced stall.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_we,
  input  logic [4:0]  cpu_rd,
  input  logic [31:0] cpu_data,
  input  logic        ext_req,
  input  logic [4:0]  ext_rd,
  input  logic [31:0] ext_data,
  output logic        ext_ack,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        cpu_stall,
  output logic [4:0]  pending
);

  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0]      FULL    = 5'(DEPTH);
  localparam logic [7:0]      BLK_MAX = 8'(STARVE_LIMIT - 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t          state, state_next;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [4:0]      count, count_next;
  logic [7:0]      blk_cnt, blk_cnt_next;
  logic            push, pop;
  logic [4:0]      fifo_rd   [DEPTH];
  logic [31:0]     fifo_data [DEPTH];

  // Acceptance looks only at registered occupancy, so a pop in the same cycle
  // never frees a slot early.
  assign ext_ack = reset_n & ext_req & (count != FULL);
  assign push    = ext_ack & (ext_rd != 5'd0);
  assign pending = count;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned and infers a latch.
    state_next   = state;
    blk_cnt_next = blk_cnt;
    pop          = 1'b0;
    rf_we        = 1'b0;
    rf_rd        = 5'd0;
    rf_data      = 32'd0;
    cpu_stall    = 1'b0;

    unique case (state)
      IDLE: begin
        blk_cnt_next = 8'd0;
        if (cpu_we) begin
          rf_we   = 1'b1;
          rf_rd   = cpu_rd;
          rf_data = cpu_data;
        end
        if (push) state_next = PEND;
      end
      PEND: begin
        if (cpu_we) begin
          rf_we   = 1'b1;
          rf_rd   = cpu_rd;
          rf_data = cpu_data;
          // The counter saturates at its limit for the one cycle before FORCE.
          if (blk_cnt == BLK_MAX) state_next   = FORCE;
          else                    blk_cnt_next = blk_cnt + 8'd1;
        end else begin
          pop          = 1'b1;
          rf_we        = 1'b1;
          rf_rd        = fifo_rd[rd_ptr];
          rf_data      = fifo_data[rd_ptr];
          blk_cnt_next = 8'd0;
        end
      end
      FORCE: begin
        cpu_stall    = 1'b1;
        pop          = 1'b1;
        rf_we        = 1'b1;
        rf_rd        = fifo_rd[rd_ptr];
        rf_data      = fifo_data[rd_ptr];
        blk_cnt_next = 8'd0;
      end
      default: state_next = IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   count_next = count + 5'd1;
      2'b01:   count_next = count - 5'd1;
      default: count_next = count;
    endcase

    if (pop) state_next = (count_next == 5'd0) ? IDLE : PEND;

    // Outputs are quiet for the whole reset, whatever the processor drives.
    if (!reset_n) begin
      rf_we     = 1'b0;
      rf_rd     = 5'd0;
      rf_data   = 32'd0;
      cpu_stall = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state   <= IDLE;
      count   <= 5'd0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      blk_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      count   <= count_next;
      blk_cnt <= blk_cnt_next;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone decide which
  // entries are valid, so reset discards contents without clearing them.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= ext_rd;
      fifo_data[wr_ptr] <= ext_data;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter (DEPTH=4, STARVE_LIMIT=4); queued
// external writes are tracked in a scoreboard and matched when they reach rf_*.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_we;
  logic [4:0]  cpu_rd;
  logic [31:0] cpu_data;
  logic        ext_req;
  logic [4:0]  ext_rd;
  logic [31:0] ext_data;
  logic        ext_ack;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_data;
  logic        cpu_stall;
  logic [4:0]  pending;

  int  n_cmp = 0;
  int  n_err = 0;
  wr_t sb[$];
  wr_t exp_w;

  regfile_write_arbiter #(.DEPTH(4), .STARVE_LIMIT(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_we   (cpu_we),
    .cpu_rd   (cpu_rd),
    .cpu_data (cpu_data),
    .ext_req  (ext_req),
    .ext_rd   (ext_rd),
    .ext_data (ext_data),
    .ext_ack  (ext_ack),
    .rf_we    (rf_we),
    .rf_rd    (rf_rd),
    .rf_data  (rf_data),
    .cpu_stall(cpu_stall),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] crd, input logic [31:0] cdat,
                       input logic req, input logic [4:0] erd, input logic [31:0] edat);
    cpu_we   = we;
    cpu_rd   = crd;
    cpu_data = cdat;
    ext_req  = req;
    ext_rd   = erd;
    ext_data = edat;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expect the oldest queued external write on the regfile port this cycle.
  task automatic chk_ext_write(input string tag);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      exp_w = sb.pop_front();
      chk({tag, "_we"},   {31'd0, rf_we}, 32'd1);
      chk({tag, "_rd"},   {27'd0, rf_rd}, {27'd0, exp_w.rd});
      chk({tag, "_data"}, rf_data, exp_w.data);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1'b1, 5'd5, 32'h55, 1'b1, 5'd3, 32'h99);
    tick();
    chk("rst_rf_we",   {31'd0, rf_we}, 32'd0);
    chk("rst_rf_rd",   {27'd0, rf_rd}, 32'd0);
    chk("rst_rf_data", rf_data, 32'd0);
    chk("rst_ext_ack", {31'd0, ext_ack}, 32'd0);
    chk("rst_stall",   {31'd0, cpu_stall}, 32'd0);
    chk("rst_pending", {27'd0, pending}, 32'd0);
    ext_req = 1'b0;
    cpu_we  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Idle pass-through and zeroed outputs when nobody writes.
    drive(1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    chk("idle_we",    {31'd0, rf_we}, 32'd1);
    chk("idle_rd",    {27'd0, rf_rd}, 32'd5);
    chk("idle_data",  rf_data, 32'h1234);
    chk("idle_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    drive(1'b0, 5'd7, 32'hdead, 1'b0, 5'd0, 32'd0);
    chk("quiet_we",   {31'd0, rf_we}, 32'd0);
    chk("quiet_rd",   {27'd0, rf_rd}, 32'd0);
    chk("quiet_data", rf_data, 32'd0);
    tick();

    // Slot steal: written exactly one cycle after its ack edge.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd30, 32'd7);
    chk("steal_ack", {31'd0, ext_ack}, 32'd1);
    chk("steal_no_same_cycle", {31'd0, rf_we}, 32'd0);
    sb.push_back('{rd: 5'd30, data: 32'd7});
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("steal_pending1", {27'd0, pending}, 32'd1);
    chk_ext_write("steal");
    chk("steal_stall", {31'd0, cpu_stall}, 32'd0);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("steal_pending0", {27'd0, pending}, 32'd0);
    tick();

    // Register zero: acknowledged but dropped.
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'd9);
    chk("zero_ack", {31'd0, ext_ack}, 32'd1);
    tick();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("zero_pending", {27'd0, pending}, 32'd0);
    chk("zero_no_we",   {31'd0, rf_we}, 32'd0);
    tick();

    // Starvation: four blocked cycles, one forced cycle, then idle.
    drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd12, 32'hab);
    chk("starve_ack",   {31'd0, ext_ack}, 32'd1);
    chk("starve_cpu_rd", {27'd0, rf_rd}, 32'd3);
    sb.push_back('{rd: 5'd12, data: 32'hab});
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'(4 + i), 32'(32'h40 + i), 1'b0, 5'd0, 32'd0);
      chk($sformatf("starve_blk%0d_stall", i), {31'd0, cpu_stall}, 32'd0);
      chk($sformatf("starve_blk%0d_rd", i), {27'd0, rf_rd}, 32'(4 + i));
      chk($sformatf("starve_blk%0d_pend", i), {27'd0, pending}, 32'd1);
      tick();
    end
    drive(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    chk("force_stall", {31'd0, cpu_stall}, 32'd1);
    chk_ext_write("force");
    tick();
    drive(1'b1, 5'd10, 32'haa, 1'b0, 5'd0, 32'd0);
    chk("after_force_stall", {31'd0, cpu_stall}, 32'd0);
    chk("after_force_rd",    {27'd0, rf_rd}, 32'd10);
    chk("after_force_pend",  {27'd0, pending}, 32'd0);
    tick();

    // Full FIFO: four accepted, fifth held off until a pop has registered.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd2, 32'h22, 1'b1, 5'(i + 1), 32'(32'h100 + i));
      chk($sformatf("fill%0d_ack", i), {31'd0, ext_ack}, 32'd1);
      sb.push_back('{rd: 5'(i + 1), data: 32'(32'h100 + i)});
      tick();
    end
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd5, 32'h104);
    chk("full_pending", {27'd0, pending}, 32'd4);
    chk("full_ack",     {31'd0, ext_ack}, 32'd0);
    tick();
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd5, 32'h104);
    chk("full_force_stall", {31'd0, cpu_stall}, 32'd1);
    chk("full_force_ack",   {31'd0, ext_ack}, 32'd0);
    chk_ext_write("full_pop0");
    tick();
    drive(1'b0, 5'd2, 32'h22, 1'b1, 5'd5, 32'h104);
    chk("full_retry_ack", {31'd0, ext_ack}, 32'd1);
    chk("full_retry_pend", {27'd0, pending}, 32'd3);
    chk_ext_write("full_pop1");
    sb.push_back('{rd: 5'd5, data: 32'h104});
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk($sformatf("drain%0d_pend", i), {27'd0, pending}, 32'(3 - i));
      chk_ext_write($sformatf("drain%0d", i));
      tick();
    end
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("drained_pend", {27'd0, pending}, 32'd0);
    chk("drained_we",   {31'd0, rf_we}, 32'd0);
    tick();

    // Asynchronous reset with three queued entries.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'd1, 32'h11, 1'b1, 5'(20 + i), 32'(32'h200 + i));
      sb.push_back('{rd: 5'(20 + i), data: 32'(32'h200 + i)});
      tick();
    end
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd25, 32'h250);
    chk("pre_rst_pend", {27'd0, pending}, 32'd3);
    reset_n = 1'b0;
    #1;
    chk("arst_we",      {31'd0, rf_we}, 32'd0);
    chk("arst_rd",      {27'd0, rf_rd}, 32'd0);
    chk("arst_data",    rf_data, 32'd0);
    chk("arst_pend",    {27'd0, pending}, 32'd0);
    chk("arst_ack",     {31'd0, ext_ack}, 32'd0);
    chk("arst_stall",   {31'd0, cpu_stall}, 32'd0);
    sb.delete();
    @(negedge clk);
    ext_req = 1'b0;
    cpu_we  = 1'b0;
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      chk($sformatf("post_rst%0d_we", i),   {31'd0, rf_we}, 32'd0);
      chk($sformatf("post_rst%0d_pend", i), {27'd0, pending}, 32'd0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
